// File: rtl/sync_fifo_counted_pkg.sv
// rtl/sync_fifo_counted_pkg.sv - shared defaults and per-edge operation encoding for the counted FIFO
package sync_fifo_counted_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  // {push_ok, pop_ok} packed into one code so the count update reads as a single case
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo_counted_if.sv
// rtl/sync_fifo_counted_if.sv - push/pop/status bundle between producer/consumer and the counted FIFO
interface sync_fifo_counted_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CNT_W-1:0]  words;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, words, full, empty, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, words, full, empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_counted_fifo_mem_2p.sv
// rtl/sync_fifo_counted_fifo_mem_2p.sv - DEPTH x DATA_W array, synchronous write, registered read with enable
module fifo_mem_2p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // storage is deliberately left without reset; only the output register is cleared
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_counted.sv
// rtl/sync_fifo_counted.sv - single-clock FIFO with registered occupancy, registered read and sticky error flags
module sync_fifo_counted
  import sync_fifo_counted_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_counted_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full_q;
  logic              empty_q;
  logic              push_ok;
  logic              pop_ok;
  logic              rd_valid_q;
  logic              overflow_q;
  logic              underflow_q;
  fifo_op_e          op;

  // status is decoded only from the registered count, never from wr_en/rd_en
  assign full_q  = (count == CNT_W'(DEPTH));
  assign empty_q = (count == '0);

  assign push_ok = bus.wr_en & ~full_q & ~bus.clr;
  assign pop_ok  = bus.rd_en & ~empty_q & ~bus.clr;
  assign op      = fifo_op_e'({push_ok, pop_ok});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid_q <= pop_ok;
      if (bus.wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );

  assign bus.words     = count;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_counted.sv
// tb/tb_sync_fifo_counted.sv - directed and randomized checks of sync_fifo_counted against a queue model
module tb_sync_fifo_counted;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_counted_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_counted #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_data = '0;
  bit                m_valid = 1'b0;
  bit                m_ovf = 1'b0;
  bit                m_udf = 1'b0;
  int                peak = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".words"},     bus.words,     m_q.size());
    check({ph, ".full"},      bus.full,      m_q.size() == DEPTH);
    check({ph, ".empty"},     bus.empty,     m_q.size() == 0);
    check({ph, ".rd_valid"},  bus.rd_valid,  m_valid);
    check({ph, ".rd_data"},   bus.rd_data,   m_data);
    check({ph, ".overflow"},  bus.overflow,  m_ovf);
    check({ph, ".underflow"}, bus.underflow, m_udf);
  endtask

  // One clock: inputs applied at the falling edge, model advanced, outputs compared at the next falling edge.
  task automatic step(input string ph, input bit w, input logic [DATA_W-1:0] d, input bit r, input bit c);
    bit was_full, was_empty;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.clr     = c;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (c) begin
      m_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      m_valid = r && !was_empty;
      if (m_valid) m_data = m_q.pop_front();
      if (w && !was_full) m_q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
    end
    if (m_q.size() > peak) peak = m_q.size();
    @(posedge clk);
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step("fill_aa", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("fill_aa.peak_words", bus.words, 8);
    step("push_full", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("push_full.ovf_set", bus.overflow, 1);
    step("clr1", 1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 1; i <= 5; i++) step("push_seq", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step("pop_seq", 1'b0, 8'h00, 1'b1, 1'b0);
      check("pop_seq.order", bus.rd_data, i);
    end
    step("pop_seq_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) step("prefill4", 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("both_at4", 1'b1, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("drain4", 1'b0, 8'h00, 1'b1, 1'b0);

    step("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);
    check("pop_empty.udf_set", bus.underflow, 1);
    step("push_pop_empty", 1'b1, 8'h5C, 1'b1, 1'b0);
    step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr2.udf_clear", bus.underflow, 0);

    for (int i = 0; i < 8; i++) step("fill_rand", 1'b1, 8'($urandom), 1'b0, 1'b0);
    step("both_at_full", 1'b1, 8'h77, 1'b1, 1'b0);
    check("both_at_full.words", bus.words, 7);

    step("pre_rst", 1'b1, 8'h3C, 1'b1, 1'b0);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = ((i / 100) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      step("rand", ($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < rp),
           ($urandom_range(99) < 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
